// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Streams 32-bit instruction words into a byte-wide instruction
//            memory (little-endian, four byte writes per word) and holds the
//            core until a complete program image has been written.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = 7,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-2:0] word_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   // Pointer is one bit wider than the address so "memory full" is visible.
   localparam logic [ADDR_W:0] BASE_PTR  = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] END_PTR   = (ADDR_W+1)'(MEM_BYTES);
   localparam logic [ADDR_W:0] WORD_STEP = (ADDR_W+1)'(4);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W:0]   ptr;
   logic [ADDR_W:0]   ptr_plus;
   logic [1:0]        byte_idx;
   logic [31:0]       byte_shift;   // latched word, shifted one byte per write
   logic              last_q;

   assign ptr_plus  = ptr + WORD_STEP;
   // Low byte of the shift register is the byte currently being written; it
   // stays put after the final write so the data bus holds its last value.
   assign mem_wdata = byte_shift[7:0];

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      core_hold = 1'b1;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_LOAD;
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = S_WRITE;
         end
         S_WRITE: begin
            mem_we = 1'b1;
            if (byte_idx == 2'd3) begin
               if (last_q)                   state_nx = S_DONE;
               else if (ptr_plus == END_PTR) state_nx = S_ERR;
               else                          state_nx = S_LOAD;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            core_hold = 1'b0;
            if (start) state_nx = S_LOAD;
         end
         S_ERR: begin
            error = 1'b1;
            if (start) state_nx = S_LOAD;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: word capture, byte sequencing, pointer and word counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr        <= BASE_PTR;
         byte_idx   <= 2'd0;
         byte_shift <= 32'd0;
         last_q     <= 1'b0;
         mem_addr   <= '0;
         word_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  ptr        <= BASE_PTR;
                  word_count <= '0;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  byte_shift <= in_data;
                  last_q     <= in_last;
                  byte_idx   <= 2'd0;
                  mem_addr   <= ptr[ADDR_W-1:0];
               end
            end
            S_WRITE: begin
               if (byte_idx == 2'd3) begin
                  ptr        <= ptr_plus;
                  word_count <= word_count + (ADDR_W-1)'(1);
               end else begin
                  byte_idx   <= byte_idx + 2'd1;
                  mem_addr   <= mem_addr + ADDR_W'(1);
                  byte_shift <= {8'h00, byte_shift[31:8]};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
